keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4-row × 3-column telephone-style key matrix, debounces it, and produces the level signals the microwave front end consumes. Outputs are a one-hot `keypad[9:0]` digit bus plus active-low `startn` (`*` key) and `stopn` (`#` key). It is the producing end of the keypad interface: it sits between the physical matrix pins and the input encoder / magnetron logic inside the microwave controller.

## Interface
- `SCAN_DIV`, default 4: clock cycles each row is driven low. Must be ≥4.
- `DEBOUNCE_SCANS`, default 3: consecutive identical full-scan results required to accept a press or a release. Must be ≥1.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `clearn`  in  1  reset, synchronous, active-low.
- `col_n`  in  3  matrix column returns, asynchronous, pulled up; 0 = key closed on the currently driven row.
- `row_n`  out  4  row drives, active-low; exactly one bit low at all times.
- `keypad`  out  10  one-hot digit held while digit key is accepted; bit d = digit d.
- `startn`  out  1  low while `*` is accepted.
- `stopn`  out  1  low while `#` is accepted.

## Operation
- **Synchronizer:** `col_n` passes through a 2-flop synchronizer (reset value 3'b111) before any use.
- **Scan engine:**
  - The divider counts 0..SCAN_DIV-1, width clog2(SCAN_DIV).
  - On terminal count, the synchronized columns are sampled into snapshot bits [row*3+2 : row*3], and the row advances 0→1→2→3→0.
  - `row_n` is 4'b1110 for row 0, 4'b1101 for row 1, and so on.
  - Sampling at the last cycle of a slot guarantees the synchronizer has settled, which is why SCAN_DIV ≥ 4.
- **Scan end:** the sample of row 3. The 12-bit snapshot is evaluated to a code:
  - Exactly one bit set → that key.
  - Zero keys, or two or more keys → NONE.
- **Key map** (row, col):
  - (0,0..2) = 1, 2, 3
  - (1,0..2) = 4, 5, 6
  - (2,0..2) = 7, 8, 9
  - (3,0) = `*`, (3,1) = 0, (3,2) = `#`
- **FSM** (evaluated only at scan end; otherwise it holds state). Registers: `cand` (candidate key), `cnt` (width clog2(DEBOUNCE_SCANS+1)).
  - IDLE: code ≠ NONE → `cand`=code, `cnt`=1. If DEBOUNCE_SCANS=1 go straight to PRESSED; else go to DEBOUNCE.
  - DEBOUNCE:
    - code == `cand` → `cnt`++; when `cnt` reaches DEBOUNCE_SCANS → PRESSED, `cnt`=0.
    - code == NONE → IDLE.
    - other key → `cand`=code, `cnt`=1 (stay).
  - PRESSED:
    - code == `cand` → `cnt`=0.
    - otherwise (including NONE and multi-key) → `cnt`++; when `cnt` reaches DEBOUNCE_SCANS → IDLE.
- **Outputs:** registered, decoded from state and `cand`.
  - Active only in PRESSED: `keypad` bit, or `startn`=0, or `stopn`=0, for `cand`.
  - All other states: `keypad`=0, `startn`=1, `stopn`=1.
  - At most one of the three outputs is active at any time.
- **Multi-key:** never asserts a new key. A second key joining a held key counts as release of the held key.

## Timing
- **Reset** (`clearn`=0 at an edge), takes effect the same edge and may occur mid-scan or mid-press:
  - `row_n`=4'b1110, divider=0, snapshot=0, state IDLE, `cand`=0, `cnt`=0.
  - `keypad`=0, `startn`=1, `stopn`=1.
- **Scan period:** 4·SCAN_DIV cycles. One scan end every period.
- **Press latency:** from the first scan end with a stable single key, outputs assert the cycle after the DEBOUNCE_SCANS-th consecutive matching scan end.
- **Release latency:** from the first non-matching scan end, outputs deassert the cycle after the DEBOUNCE_SCANS-th consecutive non-matching scan end.
- **Row change:** `row_n` changes on the same edge as the terminal-count sample.

## Test plan
The bench models the matrix: `col_n[c]`=0 iff `row_n[r]`=0 and key (r,c) is held. Use SCAN_DIV=4, DEBOUNCE_SCANS=3 (scan period 16 cycles).
- **Reset:** hold `clearn`=0 for 2 cycles, then release → `row_n`=4'b1110, `keypad`=0, `startn`=`stopn`=1. `row_n` then cycles 1110→1101→1011→0111 every 4 cycles.
- **Digit press/release:** hold key 5 (1,1) for 100 cycles → `keypad`=10'b0000100000 after 3 matching scans. Release → `keypad`=0 after 3 NONE scans (≈48 cycles).
- **Bounce:** key 7 toggled every 10 cycles for 60 cycles, then held → no assertion during bouncing. `keypad[7]` asserts only after 3 clean consecutive scans.
- **Start/stop keys:** press `*` → `startn`=0, `keypad`=0. Release, then press `#` → `stopn`=0, `startn`=1.
- **Multi-key:** hold 2 with `keypad[2]`=1, then add 9 → `keypad` drops to 0 after 3 scans and stays 0 while both are held. Release 2 → `keypad[9]` asserts after 3 scans.
- **Reset mid-press:** with `keypad[0]`=1 and 0 still held, pulse `clearn`=0 for one cycle → outputs clear on that edge. `keypad[0]` reasserts after 3 full scans plus up to 1 partial scan.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: matrix-side and front-end-side signals of the keypad scanner.
//   col_n  [2:0] column returns from the matrix (pulled up, 0 = closed key)
//   row_n  [3:0] active-low row drives, exactly one bit low
//   keypad [9:0] one-hot accepted digit
//   startn       low while '*' is accepted
//   stopn        low while '#' is accepted
// master = scanner side, slave = matrix / consumer side.
interface keypad_scanner_if;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [9:0] keypad;
    logic       startn;
    logic       stopn;

    modport master (
        input  col_n,
        output row_n,
        output keypad,
        output startn,
        output stopn
    );

    modport slave (
        output col_n,
        input  row_n,
        input  keypad,
        input  startn,
        input  stopn
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 telephone key matrix, debounces single-key
// presses and drives one-hot digit / start / stop level outputs.
// Ports:
//   clk     system clock, rising edge
//   clearn  synchronous active-low reset
//   kp      keypad_scanner_if.master (col_n in; row_n, keypad, startn, stopn out)
// Parameters:
//   SCAN_DIV       cycles each row is driven (>= 4)
//   DEBOUNCE_SCANS consecutive identical scans to accept a press or release (>= 1)
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic             clk,
    input  logic             clearn,
    keypad_scanner_if.master kp
);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int unsigned KEY_W = 4;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Key codes: 0..9 digits, then '*', '#', and "no single key"
    localparam logic [KEY_W-1:0] KEY_STAR = 4'd10;
    localparam logic [KEY_W-1:0] KEY_HASH = 4'd11;
    localparam logic [KEY_W-1:0] KEY_NONE = 4'd15;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;

    logic [2:0]       r_col_meta;
    logic [2:0]       r_col_sync;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row;
    logic [3:0]       r_row_n;
    logic [11:0]      r_snap;
    logic [1:0]       r_state;
    logic [KEY_W-1:0] r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [9:0]       r_keypad;
    logic             r_startn;
    logic             r_stopn;

    logic             w_tc;
    logic             w_scan_end;
    logic [11:0]      w_snap_full;
    logic             w_one_hot;
    logic [KEY_W-1:0] w_code;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [1:0]       w_state_nxt;
    logic [KEY_W-1:0] w_cand_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [9:0]       w_keypad_c;
    logic             w_startn_c;
    logic             w_stopn_c;

    // Snapshot bit row*3+col -> key code
    function automatic logic [KEY_W-1:0] key_of_bit(input int unsigned idx);
        logic [KEY_W-1:0] code;
        code = KEY_HASH;
        if (idx < 9)        code = KEY_W'(idx + 1);
        else if (idx == 9)  code = KEY_STAR;
        else if (idx == 10) code = 4'd0;
        return code;
    endfunction

    assign w_tc       = (r_div == DIV_LAST);
    assign w_scan_end = w_tc && (r_row == 2'd3);
    assign w_cnt_inc  = r_cnt + CNT_ONE;

    // Snapshot as it will look after this cycle's sample (closed key = 1)
    always_comb begin
        w_snap_full = r_snap;
        case (r_row)
            2'd0:    w_snap_full[2:0]  = ~r_col_sync;
            2'd1:    w_snap_full[5:3]  = ~r_col_sync;
            2'd2:    w_snap_full[8:6]  = ~r_col_sync;
            default: w_snap_full[11:9] = ~r_col_sync;
        endcase
    end

    // Full-scan evaluation: exactly one closed key yields its code
    always_comb begin
        w_code    = KEY_NONE;
        w_one_hot = (w_snap_full != 12'd0) &&
                    ((w_snap_full & (w_snap_full - 12'd1)) == 12'd0);
        if (w_one_hot) begin
            for (int unsigned i = 0; i < 12; i++) begin
                if (w_snap_full[i]) w_code = key_of_bit(i);
            end
        end
    end

    // Synchronizer, divider, row rotation and snapshot capture
    always_ff @(posedge clk) begin
        if (!clearn) begin
            r_col_meta <= 3'b111;
            r_col_sync <= 3'b111;
            r_div      <= '0;
            r_row      <= 2'd0;
            r_row_n    <= 4'b1110;
            r_snap     <= '0;
        end else begin
            r_col_meta <= kp.col_n;
            r_col_sync <= r_col_meta;
            if (w_tc) begin
                r_div   <= '0;
                r_snap  <= w_snap_full;
                r_row   <= r_row + 2'd1;
                r_row_n <= {r_row_n[2:0], r_row_n[3]};
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    // Debounce FSM next state; only advances at scan end
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        if (w_scan_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_code != KEY_NONE) begin
                        w_cand_nxt = w_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            // Release counting in PRESSED starts from zero
                            w_state_nxt = ST_PRESSED;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_DEBOUNCE;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_code == r_cand) begin
                        if (w_cnt_inc == CNT_DONE) begin
                            w_state_nxt = ST_PRESSED;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else if (w_code == KEY_NONE) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cand_nxt = w_code;
                        w_cnt_nxt  = CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    // Any non-matching scan (none, other key, multi-key) counts as release
                    if (w_code == r_cand) begin
                        w_cnt_nxt = '0;
                    end else if (w_cnt_inc == CNT_DONE) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs move with the state register
    always_comb begin
        w_keypad_c = '0;
        w_startn_c = 1'b1;
        w_stopn_c  = 1'b1;
        if (w_state_nxt == ST_PRESSED) begin
            if (w_cand_nxt == KEY_STAR) begin
                w_startn_c = 1'b0;
            end else if (w_cand_nxt == KEY_HASH) begin
                w_stopn_c = 1'b0;
            end else begin
                for (int unsigned d = 0; d < 10; d++) begin
                    w_keypad_c[d] = (w_cand_nxt == KEY_W'(d));
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!clearn) begin
            r_state <= ST_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!clearn) begin
            r_keypad <= '0;
            r_startn <= 1'b1;
            r_stopn  <= 1'b1;
        end else begin
            r_keypad <= w_keypad_c;
            r_startn <= w_startn_c;
            r_stopn  <= w_stopn_c;
        end
    end

    assign kp.row_n  = r_row_n;
    assign kp.keypad = r_keypad;
    assign kp.startn = r_startn;
    assign kp.stopn  = r_stopn;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: matrix model plus scoreboard of expected output changes
// for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3, scan period 16 cycles).
module tb_keypad_scanner;
    localparam int unsigned SCAN_DIV       = 4;
    localparam int unsigned DEBOUNCE_SCANS = 3;
    localparam int          PERIOD         = 16;
    localparam int          LAT            = 48;

    localparam logic [11:0] OUT_IDLE  = {10'd0, 1'b1, 1'b1};
    localparam logic [11:0] OUT_START = {10'd0, 1'b0, 1'b1};
    localparam logic [11:0] OUT_STOP  = {10'd0, 1'b1, 1'b0};

    typedef struct packed {
        logic [11:0] val;
        int          lo;
        int          hi;
    } exp_t;

    logic clk    = 1'b0;
    logic clearn = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk    (clk),
        .clearn (clearn),
        .kp     (kp)
    );

    // Held keys, bit row*3+col
    logic [11:0] keys = '0;

    // Matrix: column pulled low when its key is held on the driven row
    always_comb begin
        kp.col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!kp.row_n[r] && keys[r*3+c]) kp.col_n[c] = 1'b0;
            end
        end
    end

    // Cycles since the last reset edge
    int tick = 0;
    always @(posedge clk) begin
        if (!clearn) tick <= 0;
        else         tick <= tick + 1;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    string       sb_tag[$];
    logic        mon_en = 1'b0;
    logic [11:0] prev_obs = OUT_IDLE;
    logic [11:0] mon_obs;
    exp_t        mon_e;
    string       mon_tag;

    function automatic logic [11:0] digit_out(input int d);
        logic [9:0] k;
        k    = '0;
        k[d] = 1'b1;
        return {k, 2'b11};
    endfunction

    function automatic logic [11:0] outs();
        return {kp.keypad, kp.startn, kp.stopn};
    endfunction

    task automatic expect_out(input string tag, input logic [11:0] val, input int lo, input int hi);
        exp_t e;
        e.val = val;
        e.lo  = lo;
        e.hi  = hi;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wait_sb(input string tag, input int budget);
        int b;
        b = 0;
        while (sb.size() != 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        n_checks++;
        assert (sb.size() == 0) else begin
            n_errors++;
            $error("FAIL %s_timeout got %0d pending exp 0", tag, sb.size());
            sb.delete();
            sb_tag.delete();
        end
    endtask

    task automatic wait_tick(input int k);
        int b;
        b = 0;
        while (tick != k && b < 1000) begin
            @(negedge clk);
            b++;
        end
    endtask

    // Advance to the negedge right after the next scan-end edge
    task automatic to_scan_end();
        do @(negedge clk); while (!((tick % PERIOD) == 0 && tick != 0));
    endtask

    // Output monitor: every change must match the head of the scoreboard
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            mon_obs = outs();
            if (mon_obs !== prev_obs) begin
                n_checks++;
                assert (sb.size() != 0) else begin
                    n_errors++;
                    $error("FAIL unexpected_change got %h exp %h at tick %0d", mon_obs, prev_obs, tick);
                end
                if (sb.size() != 0) begin
                    mon_e   = sb.pop_front();
                    mon_tag = sb_tag.pop_front();
                    n_checks++;
                    assert (mon_obs === mon_e.val) else begin
                        n_errors++;
                        $error("FAIL %s_value got %h exp %h", mon_tag, mon_obs, mon_e.val);
                    end
                    n_checks++;
                    assert (tick >= mon_e.lo && tick <= mon_e.hi) else begin
                        n_errors++;
                        $error("FAIL %s_time got tick %0d exp %0d..%0d", mon_tag, tick, mon_e.lo, mon_e.hi);
                    end
                end
                prev_obs = mon_obs;
            end
        end
    end

    // Press key bit kb at a scan end and expect val after the debounce latency
    task automatic press(input string tag, input int kb, input logic [11:0] val);
        int t;
        to_scan_end();
        t = tick;
        keys[kb] = 1'b1;
        expect_out(tag, val, t + LAT, t + LAT + 1);
        wait_sb(tag, 80);
    endtask

    task automatic release_key(input string tag, input int kb, input logic [11:0] val);
        int t;
        to_scan_end();
        t = tick;
        keys[kb] = 1'b0;
        expect_out(tag, val, t + LAT, t + LAT + 1);
        wait_sb(tag, 80);
    endtask

    initial begin
        int          row_ticks [6];
        logic [3:0]  row_exp   [6];
        int          t;

        row_ticks = '{1, 3, 4, 8, 12, 16};
        row_exp   = '{4'b1110, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // Reset held for two edges
        clearn = 1'b0;
        keys   = '0;
        repeat (2) @(negedge clk);
        check("rst_row", {8'd0, kp.row_n}, {8'd0, 4'b1110});
        check("rst_out", outs(), OUT_IDLE);
        clearn   = 1'b1;
        prev_obs = OUT_IDLE;
        mon_en   = 1'b1;

        // Row walk, changing on the terminal-count edge
        for (int i = 0; i < 6; i++) begin
            wait_tick(row_ticks[i]);
            check($sformatf("row_t%0d", row_ticks[i]), {8'd0, kp.row_n}, {8'd0, row_exp[i]});
        end

        // Digit 5 at (1,1): press, hold ~100 cycles, release
        to_scan_end();
        t = tick;
        keys[4] = 1'b1;
        expect_out("press5", digit_out(5), t + LAT, t + LAT + 1);
        wait_sb("press5", 80);
        wait_tick(t + 100);
        check("hold5", outs(), digit_out(5));
        release_key("rel5", 4, OUT_IDLE);

        // Key 7 at (2,0) bounces every 10 cycles for 60 cycles, then held
        to_scan_end();
        t = tick;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            keys[6] = (i % 2 == 0);
            repeat (10) @(negedge clk);
        end
        check("bounce7_quiet", outs(), OUT_IDLE);
        t = tick;
        keys[6] = 1'b1;
        expect_out("press7", digit_out(7), t + LAT, t + LAT + 1);
        wait_sb("press7", 80);
        release_key("rel7", 6, OUT_IDLE);

        // '*' at (3,0) and '#' at (3,2)
        press("press_star", 9, OUT_START);
        release_key("rel_star", 9, OUT_IDLE);
        press("press_hash", 11, OUT_STOP);
        release_key("rel_hash", 11, OUT_IDLE);

        // Multi-key: 2 held, 9 joins -> release; 2 lifts -> 9 accepted
        press("press2", 1, digit_out(2));
        to_scan_end();
        t = tick;
        keys[8] = 1'b1;
        expect_out("multi_drop", OUT_IDLE, t + LAT, t + LAT + 1);
        wait_sb("multi_drop", 80);
        repeat (4 * PERIOD) @(negedge clk);
        check("multi_hold", outs(), OUT_IDLE);
        release_key("press9", 1, digit_out(9));
        release_key("rel9", 8, OUT_IDLE);

        // Reset mid-press with digit 0 at (3,1) still held
        press("press0", 10, digit_out(0));
        repeat (5) @(negedge clk);
        clearn = 1'b0;
        expect_out("rst_mid", OUT_IDLE, 0, 0);
        @(negedge clk);
        clearn = 1'b1;
        check("rst_mid_row", {8'd0, kp.row_n}, {8'd0, 4'b1110});
        wait_sb("rst_mid", 4);
        expect_out("repress0", digit_out(0), LAT, LAT + PERIOD + 1);
        wait_sb("repress0", 100);
        release_key("rel0", 10, OUT_IDLE);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global bound on run time
    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end
endmodule
